// File: rtl/regfile_arbiter.sv
// Round-robin arbiter and access sequencer in front of an 8 x 16-bit register file.
// Each granted access runs IDLE -> ACCESS -> ACK, with every register-file control driven from flops.
module regfile_arbiter #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_a,
    input  logic              req_b,
    input  logic              we_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              ack_a,
    output logic              ack_b,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              rf_write,
    output logic [ADDR_W-1:0] rf_writenum,
    output logic [ADDR_W-1:0] rf_readnum,
    output logic [DATA_W-1:0] rf_data_in,
    input  logic [DATA_W-1:0] rf_data_out
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_ACK    = 2'd2;

    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_B = 1'b1;

    logic [1:0]        state_q,       state_d;
    logic              last_grant_q,  last_grant_d;
    logic              op_sel_q,      op_sel_d;
    logic              op_we_q,       op_we_d;
    logic              ack_a_q,       ack_a_d;
    logic              ack_b_q,       ack_b_d;
    logic              busy_q,        busy_d;
    logic              rf_write_q,    rf_write_d;
    logic [ADDR_W-1:0] rf_writenum_q, rf_writenum_d;
    logic [ADDR_W-1:0] rf_readnum_q,  rf_readnum_d;
    logic [DATA_W-1:0] rf_data_in_q,  rf_data_in_d;
    logic [DATA_W-1:0] rdata_q,       rdata_d;

    logic              grant_b_c;
    logic              win_we_c;
    logic [ADDR_W-1:0] win_addr_c;
    logic [DATA_W-1:0] win_wdata_c;

    // B wins when it is alone, or on a tie when A was granted most recently.
    always_comb begin
        grant_b_c   = req_b & (~req_a | (last_grant_q == GRANT_A));
        win_we_c    = grant_b_c ? we_b    : we_a;
        win_addr_c  = grant_b_c ? addr_b  : addr_a;
        win_wdata_c = grant_b_c ? wdata_b : wdata_a;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            last_grant_q  <= GRANT_B;
            op_sel_q      <= GRANT_A;
            op_we_q       <= 1'b0;
            ack_a_q       <= 1'b0;
            ack_b_q       <= 1'b0;
            busy_q        <= 1'b0;
            rf_write_q    <= 1'b0;
            rf_writenum_q <= '0;
            rf_readnum_q  <= '0;
            rf_data_in_q  <= '0;
            rdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            op_sel_q      <= op_sel_d;
            op_we_q       <= op_we_d;
            ack_a_q       <= ack_a_d;
            ack_b_q       <= ack_b_d;
            busy_q        <= busy_d;
            rf_write_q    <= rf_write_d;
            rf_writenum_q <= rf_writenum_d;
            rf_readnum_q  <= rf_readnum_d;
            rf_data_in_q  <= rf_data_in_d;
            rdata_q       <= rdata_d;
        end
    end

    // Outputs are computed for the next state so they are valid in the cycle that state is held.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        op_sel_d      = op_sel_q;
        op_we_d       = op_we_q;
        ack_a_d       = 1'b0;
        ack_b_d       = 1'b0;
        busy_d        = busy_q;
        rf_write_d    = 1'b0;
        rf_writenum_d = rf_writenum_q;
        rf_readnum_d  = rf_readnum_q;
        rf_data_in_d  = rf_data_in_q;
        rdata_d       = rdata_q;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (req_a || req_b) begin
                    state_d      = ST_ACCESS;
                    busy_d       = 1'b1;
                    last_grant_d = grant_b_c;
                    op_sel_d     = grant_b_c;
                    op_we_d      = win_we_c;
                    rf_write_d   = win_we_c;
                    if (win_we_c) begin
                        rf_writenum_d = win_addr_c;
                        rf_data_in_d  = win_wdata_c;
                    end else begin
                        rf_readnum_d  = win_addr_c;
                    end
                end
            end
            ST_ACCESS: begin
                state_d = ST_ACK;
                busy_d  = 1'b1;
                if (!op_we_q) begin
                    rdata_d = rf_data_out;
                end
                ack_a_d = (op_sel_q == GRANT_A);
                ack_b_d = (op_sel_q == GRANT_B);
            end
            ST_ACK: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign ack_a       = ack_a_q;
    assign ack_b       = ack_b_q;
    assign busy        = busy_q;
    assign rf_write    = rf_write_q;
    assign rf_writenum = rf_writenum_q;
    assign rf_readnum  = rf_readnum_q;
    assign rf_data_in  = rf_data_in_q;
    assign rdata       = rdata_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural 8 x 16 register file attached.
module tb_regfile_arbiter;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_a = 1'b0, req_b = 1'b0;
    logic          we_a = 1'b0, we_b = 1'b0;
    logic [AW-1:0] addr_a = '0, addr_b = '0;
    logic [DW-1:0] wdata_a = '0, wdata_b = '0;
    logic          ack_a, ack_b, busy, rf_write;
    logic [DW-1:0] rdata, rf_data_in, rf_data_out;
    logic [AW-1:0] rf_writenum, rf_readnum;

    logic [DW-1:0] mem [8] = '{default: '0};

    int checks = 0;
    int errors = 0;

    regfile_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_a       (req_a),
        .req_b       (req_b),
        .we_a        (we_a),
        .we_b        (we_b),
        .addr_a      (addr_a),
        .addr_b      (addr_b),
        .wdata_a     (wdata_a),
        .wdata_b     (wdata_b),
        .ack_a       (ack_a),
        .ack_b       (ack_b),
        .rdata       (rdata),
        .busy        (busy),
        .rf_write    (rf_write),
        .rf_writenum (rf_writenum),
        .rf_readnum  (rf_readnum),
        .rf_data_in  (rf_data_in),
        .rf_data_out (rf_data_out)
    );

    always #5 clk = ~clk;

    // Register file: synchronous write, combinational read.
    always @(posedge clk) begin
        if (rf_write) mem[rf_writenum] <= rf_data_in;
    end
    assign rf_data_out = mem[rf_readnum];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ack_a"},       32'(ack_a),       32'd0);
        chk({tag, "_ack_b"},       32'(ack_b),       32'd0);
        chk({tag, "_busy"},        32'(busy),        32'd0);
        chk({tag, "_rf_write"},    32'(rf_write),    32'd0);
        chk({tag, "_rf_writenum"}, 32'(rf_writenum), 32'd0);
        chk({tag, "_rf_readnum"},  32'(rf_readnum),  32'd0);
        chk({tag, "_rf_data_in"},  32'(rf_data_in),  32'd0);
        chk({tag, "_rdata"},       32'(rdata),       32'd0);
    endtask

    // One uncontended access, called at a negedge with the DUT idle; exp_rd is rdata expected at ack.
    task automatic access(input string tag, input bit use_b, input bit we,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input logic [DW-1:0] exp_rd);
        if (use_b) begin
            req_b = 1'b1; we_b = we; addr_b = addr; wdata_b = wd;
        end else begin
            req_a = 1'b1; we_a = we; addr_a = addr; wdata_a = wd;
        end
        @(negedge clk);
        chk({tag, "_acc_busy"},  32'(busy),     32'd1);
        chk({tag, "_acc_write"}, 32'(rf_write), 32'(we));
        chk({tag, "_acc_ack"},   32'({ack_a, ack_b}), 32'd0);
        if (we) begin
            chk({tag, "_acc_wnum"}, 32'(rf_writenum), 32'(addr));
            chk({tag, "_acc_din"},  32'(rf_data_in),  32'(wd));
        end else begin
            chk({tag, "_acc_rnum"}, 32'(rf_readnum),  32'(addr));
        end
        @(negedge clk);
        chk({tag, "_ack_a"},     32'(ack_a),    32'(!use_b));
        chk({tag, "_ack_b"},     32'(ack_b),    32'(use_b));
        chk({tag, "_ack_write"}, 32'(rf_write), 32'd0);
        chk({tag, "_ack_rdata"}, 32'(rdata),    32'(exp_rd));
        if (use_b) req_b = 1'b0; else req_a = 1'b0;
        @(negedge clk);
        chk({tag, "_idle_ack"},  32'({ack_a, ack_b}), 32'd0);
        chk({tag, "_idle_busy"}, 32'(busy),     32'd0);
        if (we) chk({tag, "_mem"}, 32'(mem[addr]), 32'(wd));
    endtask

    initial begin
        int  na, nb;
        bit  prev_a, prev_b, expect_b;

        // Reset state
        #2;
        chk_reset_vals("rst");
        @(negedge clk);
        @(negedge clk);
        chk_reset_vals("rst_hold");
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_vals("rst_rel");

        // Tie after reset: A (write 20 to R7) must win, B (read R7) follows 3 cycles later
        req_a = 1'b1; we_a = 1'b1; addr_a = 3'd7; wdata_a = 16'd20;
        req_b = 1'b1; we_b = 1'b0; addr_b = 3'd7;
        @(negedge clk);
        chk("tie_acc_write", 32'(rf_write),    32'd1);
        chk("tie_acc_wnum",  32'(rf_writenum), 32'd7);
        @(negedge clk);
        chk("tie_ack_a",     32'(ack_a), 32'd1);
        chk("tie_ack_b_lo",  32'(ack_b), 32'd0);
        req_a = 1'b0;
        @(negedge clk);
        chk("tie_gap", 32'({ack_a, ack_b}), 32'd0);
        @(negedge clk);
        chk("tie_b_rnum",  32'(rf_readnum), 32'd7);
        chk("tie_b_write", 32'(rf_write),   32'd0);
        @(negedge clk);
        chk("tie_ack_b",   32'(ack_b), 32'd1);
        chk("tie_ack_a_lo", 32'(ack_a), 32'd0);
        chk("tie_rdata",   32'(rdata), 32'd20);
        req_b = 1'b0;
        @(negedge clk);

        // Single write/read
        access("wr_a_r2", 1'b0, 1'b1, 3'd2, 16'd18, 16'd20);
        access("rd_b_r2", 1'b1, 1'b0, 3'd2, 16'd0,  16'd18);

        // Overwrite and hold
        access("ow_wr_r2", 1'b0, 1'b1, 3'd2, 16'd1,     16'd18);
        access("ow_rd_r2", 1'b0, 1'b0, 3'd2, 16'd0,     16'd1);
        access("ow_wr_r5", 1'b0, 1'b1, 3'd5, 16'h0055,  16'd1);
        access("rd_b_r5",  1'b1, 1'b0, 3'd5, 16'd0,     16'h0055);

        // Fairness: both requesters held high for 4 accesses each, A first since B was last
        req_a = 1'b1; we_a = 1'b1; addr_a = 3'd0; wdata_a = 16'd1;
        req_b = 1'b1; we_b = 1'b0; addr_b = 3'd0;
        na = 0; nb = 0; prev_a = 1'b0; prev_b = 1'b0; expect_b = 1'b0;
        for (int cyc = 0; cyc < 60 && (na < 4 || nb < 4); cyc++) begin
            @(negedge clk);
            chk("fair_overlap", 32'(ack_a & ack_b), 32'd0);
            if (ack_a) begin
                chk("fair_order_a", 32'(expect_b), 32'd0);
                chk("fair_pulse_a", 32'(prev_a),   32'd0);
                expect_b = 1'b1;
                na++;
                if (na < 4) begin
                    addr_a = AW'(na); wdata_a = DW'(na + 1);
                end else begin
                    req_a = 1'b0;
                end
            end
            if (ack_b) begin
                chk("fair_order_b", 32'(expect_b), 32'd1);
                chk("fair_pulse_b", 32'(prev_b),   32'd0);
                chk("fair_rdata",   32'(rdata),    32'(nb + 1));
                expect_b = 1'b0;
                nb++;
                if (nb < 4) addr_b = AW'(nb); else req_b = 1'b0;
            end
            prev_a = ack_a;
            prev_b = ack_b;
        end
        chk("fair_count_a", 32'(na), 32'd4);
        chk("fair_count_b", 32'(nb), 32'd4);
        @(negedge clk);
        chk("fair_end_ack", 32'({ack_a, ack_b}), 32'd0);

        // Reset during the ACCESS cycle of a write of FFFF to R4
        req_a = 1'b1; we_a = 1'b1; addr_a = 3'd4; wdata_a = 16'hFFFF;
        @(negedge clk);
        chk("mrst_pre_write", 32'(rf_write), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("mrst");
        req_a = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mrst_r4", 32'(mem[4]), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mrst_no_ack", 32'({ack_a, ack_b}), 32'd0);
            chk("mrst_no_write", 32'(rf_write), 32'd0);
        end
        chk("mrst_r4_after", 32'(mem[4]), 32'd0);

        // Address change after sampling is ignored
        req_a = 1'b1; we_a = 1'b1; addr_a = 3'd3; wdata_a = 16'hABCD;
        @(negedge clk);
        chk("chg_wnum", 32'(rf_writenum), 32'd3);
        addr_a = 3'd6;
        @(negedge clk);
        chk("chg_ack", 32'(ack_a), 32'd1);
        req_a = 1'b0;
        @(negedge clk);
        chk("chg_r3", 32'(mem[3]), 32'hABCD);
        chk("chg_r6", 32'(mem[6]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
